multi_channel_clock_divider: RTL

Parametrised multi-channel divider that produces per-channel one-cycle `tick` strobes and 50%-duty `clk_out` square waves from the system clock. It replaces the fixed single-output divider used for millisecond timing. It also adds per-channel run-time programmable divisors, per-channel enables, glitch-free divisor updates and a global phase-realignment input. It sits beside the top-level clock source and feeds the timer, debounce and display-scan blocks.

---
 rtl/multi_channel_clock_divider.sv | 71 +++++++
 1 files changed

// File: rtl/multi_channel_clock_divider.sv
// Multi-channel divider: per-channel tick strobe and 50%-duty clock, with shadowed
// divisors that swap in only at a wrap, per-channel enables and a global phase restart.
module multi_channel_clock_divider #(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 28,
  parameter int DEFAULT_DIV = 250000,
  parameter int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] enable,
  input  logic              sync_restart,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] clk_out,
  output logic              cfg_err
);

  localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);
  localparam logic [CH_W:0]    CH_LIM  = (CH_W+1)'(NUM_CH);

  logic [CNT_W-1:0] cnt        [NUM_CH];
  logic [CNT_W-1:0] active_div [NUM_CH];
  logic [CNT_W-1:0] shadow_div [NUM_CH];
  logic             cfg_ok;

  // The channel bound only matters when NUM_CH is not a power of two.
  assign cfg_ok = cfg_we && (cfg_div != '0) && ({1'b0, cfg_ch} < CH_LIM);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt[i]        <= '0;
        active_div[i] <= DIV_RST;
        shadow_div[i] <= DIV_RST;
      end
      tick    <= '0;
      clk_out <= '0;
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= cfg_we && !cfg_ok;
      for (int i = 0; i < NUM_CH; i++) begin
        if (cfg_ok && (cfg_ch == CH_W'(i)))
          shadow_div[i] <= cfg_div;

        // active_div always takes the pre-edge shadow, so a write on a wrap edge waits one period.
        if (sync_restart) begin
          cnt[i]        <= '0;
          tick[i]       <= 1'b0;
          clk_out[i]    <= 1'b0;
          active_div[i] <= shadow_div[i];
        end else if (enable[i]) begin
          if (cnt[i] == active_div[i] - CNT_W'(1)) begin
            cnt[i]        <= '0;
            tick[i]       <= 1'b1;
            clk_out[i]    <= ~clk_out[i];
            active_div[i] <= shadow_div[i];
          end else begin
            cnt[i]  <= cnt[i] + CNT_W'(1);
            tick[i] <= 1'b0;
          end
        end else begin
          tick[i] <= 1'b0;
        end
      end
    end
  end

endmodule
